// File: rtl/mem_byte_sequencer_if.sv
// Byte-wide data memory bus: the sequencer drives it as master, the memory answers as slave.
interface mem_byte_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    logic [ADDR_W-1:0] bmem_addr;
    logic [7:0]        bmem_wdata;
    logic              bmem_re;
    logic              bmem_we;
    logic [7:0]        bmem_rdata;
    logic              bmem_ready;

    modport master (
        output bmem_addr, bmem_wdata, bmem_re, bmem_we,
        input  bmem_rdata, bmem_ready
    );

    modport slave (
        input  bmem_addr, bmem_wdata, bmem_re, bmem_we,
        output bmem_rdata, bmem_ready
    );
endinterface

// File: rtl/mem_byte_sequencer.sv
// Load/store sequencer: splits a byte/half/word access into big-endian byte transfers on a
// ready-handshaked byte memory, assembles and extends load data, and rejects illegal requests.
module mem_byte_sequencer #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [1:0]        blockSize,
    input  logic              loadUnsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              misaligned,
    mem_byte_sequencer_if.master bmem
);

    typedef enum logic [1:0] {StIdle, StXfer, StDone, StErr} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [31:0]       asm_q, asm_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        k_q, k_d;
    logic              uns_q, uns_d;
    logic              write_q, write_d;
    logic [1:0]        last_k;
    logic [4:0]        shamt;
    logic              illegal;

    function automatic logic [31:0] extend(input logic [31:0] a, input logic [1:0] size,
                                           input logic uns);
        logic [31:0] r;
        case (size)
            2'b00:   r = uns ? {24'd0, a[7:0]}  : {{24{a[7]}}, a[7:0]};
            2'b01:   r = uns ? {16'd0, a[15:0]} : {{16{a[15]}}, a[15:0]};
            default: r = a;
        endcase
        return r;
    endfunction

    always_comb begin
        case (size_q)
            2'b00:   last_k = 2'd0;
            2'b01:   last_k = 2'd1;
            default: last_k = 2'd3;
        endcase
        illegal = (memRead && memWrite) || (blockSize == 2'b10) ||
                  ((blockSize == 2'b01) && addr[0]) ||
                  ((blockSize == 2'b11) && (addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        asm_d   = asm_q;
        size_d  = size_q;
        k_d     = k_q;
        uns_d   = uns_q;
        write_d = write_q;
        case (state_q)
            StIdle: begin
                if (start && (memRead || memWrite)) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    size_d  = blockSize;
                    uns_d   = loadUnsigned;
                    write_d = memWrite;
                    k_d     = 2'd0;
                    asm_d   = 32'd0;
                    state_d = illegal ? StErr : StXfer;
                end
            end
            StXfer: begin
                if (bmem.bmem_ready) begin
                    asm_d = {asm_q[23:0], bmem.bmem_rdata};
                    k_d   = k_q + 2'd1;
                    if (k_q == last_k) begin
                        state_d = StDone;
                        // Extend here so rdata is already valid in the cycle done is high.
                        if (!write_q) rdata_d = extend(asm_d, size_q, uns_q);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            asm_q   <= 32'd0;
            size_q  <= 2'd0;
            k_q     <= 2'd0;
            uns_q   <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            asm_q   <= asm_d;
            size_q  <= size_d;
            k_q     <= k_d;
            uns_q   <= uns_d;
            write_q <= write_d;
        end
    end

    // Memory side is decoded purely from registered state, so start never reaches bmem_*.
    always_comb begin
        shamt           = {last_k - k_q, 3'b000};
        bmem.bmem_addr  = addr_q + ADDR_W'(k_q);
        bmem.bmem_wdata = wdata_q[shamt +: 8];
        bmem.bmem_re    = (state_q == StXfer) && !write_q;
        bmem.bmem_we    = (state_q == StXfer) && write_q;
        rdata           = rdata_q;
        busy            = (state_q != StIdle);
        done            = (state_q == StDone);
        misaligned      = (state_q == StErr);
    end

endmodule

// File: tb/tb_mem_byte_sequencer.sv
// Scoreboard bench for mem_byte_sequencer: a request model pushes expected byte transfers and
// responses, a monitor pops and compares them; a behavioural byte memory answers the bus.
module tb_mem_byte_sequencer;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst, start, memRead, memWrite, loadUnsigned;
    logic [1:0]    blockSize;
    logic [AW-1:0] addr;
    logic [31:0]   wdata, rdata;
    logic          busy, done, misaligned;

    mem_byte_sequencer_if #(.ADDR_W(AW)) bus ();

    mem_byte_sequencer #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .memRead(memRead), .memWrite(memWrite),
        .blockSize(blockSize), .loadUnsigned(loadUnsigned), .addr(addr), .wdata(wdata),
        .rdata(rdata), .busy(busy), .done(done), .misaligned(misaligned), .bmem(bus)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] addr; bit we; logic [7:0] data;} xfer_t;
    typedef struct {bit err; logic [31:0] rdata;} resp_t;

    xfer_t       xq[$];
    resp_t       rq[$];
    int          checks = 0, errors = 0, xfer_pops = 0, wait_cfg = 0, wc = 0;
    logic [7:0]  ref_mem [1024];
    logic [7:0]  mem     [1024];
    logic [31:0] last_rdata = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] init_byte(input int i);
        case (i)
            'h100: return 8'h12;
            'h101: return 8'h34;
            'h102: return 8'h56;
            'h103: return 8'h78;
            'h200: return 8'h80;
            'h201: return 8'h01;
            'h210: return 8'hF0;
            default: return 8'(i * 37 + 11);
        endcase
    endfunction

    // Reference model: returns 0 (ignored), -1 (rejected) or the byte count.
    function automatic int model_req(input bit rd, input bit wr, input logic [1:0] bs,
                                     input bit uns, input logic [31:0] a, input logic [31:0] wd);
        int n;
        logic [31:0] v;
        xfer_t x;
        resp_t r;
        if (!rd && !wr) return 0;
        n = (bs == 2'b00) ? 1 : (bs == 2'b01) ? 2 : 4;
        if ((rd && wr) || bs == 2'b10 || (a % 32'(n)) != 0) begin
            r.err = 1'b1;
            r.rdata = last_rdata;
            rq.push_back(r);
            return -1;
        end
        v = 32'd0;
        for (int i = 0; i < n; i++) begin
            x.addr = a + 32'(i);
            x.we = wr;
            if (wr) begin
                x.data = 8'(wd >> (8 * (n - 1 - i)));
                ref_mem[10'(x.addr)] = x.data;
            end else begin
                x.data = ref_mem[10'(x.addr)];
                v = v * 256 + 32'(x.data);
            end
            xq.push_back(x);
        end
        if (rd) begin
            if (!uns && n < 4 && v[8 * n - 1]) v = v - (32'd1 << (8 * n));
            last_rdata = v;
        end
        r.err = 1'b0;
        r.rdata = last_rdata;
        rq.push_back(r);
        return n;
    endfunction

    // Behavioural memory: ready after wait_cfg low cycles per byte (-1 = random ready).
    initial begin : memory
        logic fire, fwe, strobe;
        logic [31:0] fa;
        logic [7:0] fd;
        for (int i = 0; i < 1024; i++) mem[i] = init_byte(i);
        bus.bmem_ready = 1'b0;
        bus.bmem_rdata = 8'd0;
        forever begin
            @(negedge clk);
            strobe = bus.bmem_re || bus.bmem_we;
            fire = strobe && bus.bmem_ready;
            fwe = bus.bmem_we;
            fa = bus.bmem_addr;
            fd = bus.bmem_wdata;
            @(posedge clk);
            #1;
            if (fire && fwe) mem[10'(fa)] = fd;
            wc = (strobe && !fire) ? wc + 1 : 0;
            if (wait_cfg < 0) bus.bmem_ready = 1'($urandom_range(0, 1));
            else bus.bmem_ready = (wc >= wait_cfg);
            bus.bmem_rdata = mem[10'(bus.bmem_addr)];
        end
    end

    initial begin : monitor
        xfer_t x;
        resp_t r;
        forever begin
            @(negedge clk);
            if (bus.bmem_re || bus.bmem_we)
                chk("re_we_exclusive", 32'(bus.bmem_re & bus.bmem_we), 32'd0);
            if ((bus.bmem_re || bus.bmem_we) && bus.bmem_ready) begin
                if (xq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_xfer: got addr %h expected no transfer",
                             bus.bmem_addr);
                end else begin
                    x = xq.pop_front();
                    xfer_pops++;
                    chk("xfer_addr", bus.bmem_addr, x.addr);
                    chk("xfer_dir", 32'(bus.bmem_we), 32'(x.we));
                    if (x.we) chk("xfer_wdata", 32'(bus.bmem_wdata), 32'(x.data));
                end
            end
            if (done || misaligned) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got done=%b misaligned=%b expected none",
                             done, misaligned);
                end else begin
                    r = rq.pop_front();
                    chk("resp_misaligned", 32'(misaligned), 32'(r.err));
                    chk("resp_done", 32'(done), 32'(!r.err));
                    chk("resp_rdata", rdata, r.rdata);
                end
            end
        end
    end

    task automatic run_req(input string name, input bit rd, input bit wr, input logic [1:0] bs,
                           input bit uns, input logic [31:0] a, input logic [31:0] wd);
        int kind, exp, cyc;
        bit seen, act;
        kind = model_req(rd, wr, bs, uns, a, wd);
        exp = (wait_cfg < 0) ? -1 : (kind < 0) ? 1 : kind * (wait_cfg + 1) + 1;
        @(negedge clk);
        start = 1'b1; memRead = rd; memWrite = wr; blockSize = bs;
        loadUnsigned = uns; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        start = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        if (kind == 0) begin
            act = 1'b0;
            repeat (3) begin
                @(negedge clk);
                act = act | busy | done | misaligned;
            end
            chk({name, "_ignored"}, 32'(act), 32'd0);
            return;
        end
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clk);
            cyc++;
            seen = done || misaligned;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no response after %0d cycles expected one", name, cyc);
        end else if (exp > 0) begin
            chk({name, "_latency"}, 32'(cyc), 32'(exp));
        end
        @(negedge clk);
        chk({name, "_idle_after"}, 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int pops0, r, sel;
        bit rd, wr;
        logic [1:0] bs;
        logic [31:0] a;
        rst = 1'b1; start = 1'b0; memRead = 1'b0; memWrite = 1'b0;
        blockSize = 2'd0; loadUnsigned = 1'b0; addr = '0; wdata = 32'd0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_byte(i);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_re", 32'(bus.bmem_re), 32'd0);
        chk("rst_we", 32'(bus.bmem_we), 32'd0);
        chk("rst_addr", bus.bmem_addr, 32'd0);
        chk("rst_wdata", 32'(bus.bmem_wdata), 32'd0);

        wait_cfg = 0;
        run_req("word_load", 1, 0, 2'b11, 0, 32'h100, 32'd0);
        chk("word_load_value", rdata, 32'h12345678);
        run_req("half_signed", 1, 0, 2'b01, 0, 32'h200, 32'd0);
        chk("half_signed_value", rdata, 32'hFFFF8001);
        run_req("half_unsigned", 1, 0, 2'b01, 1, 32'h200, 32'd0);
        chk("half_unsigned_value", rdata, 32'h00008001);
        run_req("byte_signed", 1, 0, 2'b00, 0, 32'h210, 32'd0);
        chk("byte_signed_value", rdata, 32'hFFFFFFF0);

        wait_cfg = 2;
        run_req("word_store_wait", 0, 1, 2'b11, 0, 32'h40, 32'hDEADBEEF);
        chk("store_mem_40", 32'(mem[10'h40]), 32'hDE);
        chk("store_mem_43", 32'(mem[10'h43]), 32'hEF);

        wait_cfg = 0;
        run_req("rej_half", 1, 0, 2'b01, 0, 32'h201, 32'd0);
        run_req("rej_word", 0, 1, 2'b11, 0, 32'h102, 32'h11223344);
        run_req("rej_size", 1, 0, 2'b10, 0, 32'h200, 32'd0);
        run_req("rej_rdwr", 1, 1, 2'b00, 0, 32'h200, 32'd0);
        chk("rej_rdata_kept", rdata, 32'hFFFFFFF0);
        run_req("no_dir", 0, 0, 2'b00, 0, 32'h200, 32'd0);

        // Reset during the third byte of a word store.
        void'(model_req(0, 1, 2'b11, 0, 32'h300, 32'hCAFEF00D));
        pops0 = xfer_pops;
        @(negedge clk);
        start = 1'b1; memRead = 1'b0; memWrite = 1'b1; blockSize = 2'b11;
        addr = 32'h300; wdata = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        start = 1'b0; memWrite = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_re", 32'(bus.bmem_re), 32'd0);
        chk("rst_mid_we", 32'(bus.bmem_we), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        chk("rst_mid_bytes", 32'(xfer_pops - pops0), 32'd3);
        xq.delete();
        rq.delete();
        last_rdata = 32'd0;
        run_req("after_rst_load", 1, 0, 2'b00, 1, 32'h210, 32'd0);
        chk("after_rst_value", rdata, 32'h000000F0);

        // Back-to-back with start held high.
        void'(model_req(0, 1, 2'b00, 0, 32'h60, 32'h000000A5));
        void'(model_req(1, 0, 2'b00, 0, 32'h60, 32'd0));
        @(negedge clk);
        start = 1'b1; memRead = 1'b0; memWrite = 1'b1; blockSize = 2'b00;
        loadUnsigned = 1'b0; addr = 32'h60; wdata = 32'h000000A5;
        @(negedge clk);
        chk("b2b_c1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("b2b_c2_done", 32'(done), 32'd1);
        memRead = 1'b1; memWrite = 1'b0;
        @(negedge clk);
        chk("b2b_c3_gap", 32'(busy), 32'd0);
        @(negedge clk);
        chk("b2b_c4_busy", 32'(busy), 32'd1);
        start = 1'b0; memRead = 1'b0;
        @(negedge clk);
        chk("b2b_c5_done", 32'(done), 32'd1);
        @(negedge clk);
        chk("b2b_value", rdata, 32'hFFFFFFA5);

        for (int it = 0; it < 150; it++) begin
            sel = $urandom_range(0, 3);
            wait_cfg = sel - 1;
            r = $urandom_range(0, 10);
            rd = (r == 0) || (r >= 5 && r <= 9);
            wr = (r <= 4);
            bs = 2'($urandom_range(0, 3));
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (bs == 2'b11) a = a & ~32'd3;
                else if (bs == 2'b01) a = a & ~32'd1;
            end
            run_req("rand", rd, wr, bs, 1'($urandom_range(0, 1)), a, $urandom);
        end

        chk("xfer_queue_empty", 32'(xq.size()), 32'd0);
        chk("resp_queue_empty", 32'(rq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_byte_sequencer.md
# mem_byte_sequencer

Multi-cycle load/store sequencer between the processor datapath and a byte-wide data memory. It takes a decoded access (`memRead`/`memWrite`, `blockSize`, sign/zero-extension select) plus address and store data, and issues 1, 2 or 4 big-endian byte transfers with a ready handshake. It assembles and extends load data, flags misaligned or illegal requests, and holds the core stalled while a transfer is in progress.

## Interface

**Parameters**
- `ADDR_W`, default 32: byte address width.

**Ports**
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: request strobe. Sampled only in IDLE.
- `memRead`, in, 1: load request.
- `memWrite`, in, 1: store request.
- `blockSize`, in, 2: access size. 2'b00 = byte, 2'b01 = half, 2'b11 = word, 2'b10 = reserved.
- `loadUnsigned`, in, 1: 1 = zero-extend load data, 0 = sign-extend.
- `addr`, in, ADDR_W: byte address of the access.
- `wdata`, in, 32: store data, right-aligned.
- `rdata`, out, 32: extended load result. Valid from `done` until the next accepted request.
- `busy`, out, 1: request in progress. Used as the pipeline stall.
- `done`, out, 1: one-cycle pulse on successful completion.
- `misaligned`, out, 1: one-cycle pulse when a request is rejected.
- `bmem_addr`, out, ADDR_W: byte address presented to the memory.
- `bmem_wdata`, out, 8: store byte.
- `bmem_re`, out, 1: byte read strobe.
- `bmem_we`, out, 1: byte write strobe.
- `bmem_rdata`, in, 8: read byte. Valid when `bmem_ready` is high.
- `bmem_ready`, in, 1: memory accepts or completes the presented byte this cycle.

## Operation

**States:** IDLE, XFER, DONE, ERR.

**IDLE**
- When `start` is high, latch `addr`, `wdata`, `blockSize`, `loadUnsigned` and the direction.
- Request legality:
  - `memRead` and `memWrite` both high → ERR.
  - `blockSize` = 2'b10 → ERR.
  - Half access with `addr[0]` = 1 → ERR.
  - Word access with `addr[1:0]` ≠ 0 → ERR.
  - Otherwise → XFER, with byte count N = 1/2/4 and byte index k = 0.
- `start` with neither `memRead` nor `memWrite` is ignored: the block stays in IDLE with no pulse.

**XFER**
- Drive `bmem_addr` = latched address + k, and `bmem_re` or `bmem_we` as the direction requires.
- Store byte order is big-endian: byte k carries `wdata` bits [8N−1−8k −: 8].
- On `bmem_ready`:
  - Load: shift `bmem_rdata` into the assembly register, MSB first.
  - k increments.
  - When k = N−1, go to DONE.
- With `bmem_ready` low, all `bmem_*` outputs hold and k holds.

**DONE**
- Assert `done`.
- For loads, `rdata` = the assembled N bytes, sign- or zero-extended to 32 bits. Word loads ignore `loadUnsigned`.
- For stores, `rdata` is unchanged.
- Next state is IDLE.

**ERR**
- Assert `misaligned`. No `bmem_*` strobe is ever issued for the request.
- Next state is IDLE. `rdata` is unchanged.

**Outputs by state**
- `busy` is high in XFER, DONE and ERR, and low in IDLE.
- `bmem_re`/`bmem_we` are high only in XFER, and never both at once.

**Address arithmetic:** `bmem_addr` wraps modulo 2^ADDR_W. This cannot occur for aligned legal requests, but must not be special-cased.

## Timing

- **Reset values:** state IDLE; `rdata`, `busy`, `done`, `misaligned`, `bmem_re`, `bmem_we` = 0; `bmem_addr` and `bmem_wdata` = 0.
- **Reset mid-transfer:** the next edge returns the block to IDLE with all strobes low. No `done` is produced, and partial stores are not rolled back.
- **Latency, `bmem_ready` tied high:**
  - `start` sampled at edge 0.
  - Strobes high on cycles 1..N.
  - `done` on cycle N+1.
  - Next request accepted on cycle N+2.
- **Memory wait states:** each low-`bmem_ready` cycle adds exactly one cycle.
- **Errors:** `misaligned` pulses on cycle 1; IDLE on cycle 2.
- **Combinational paths:** none from `start` to `bmem_*`. All memory-side outputs are registered or decoded from state.

## Test plan

- **Word load, ready tied 1.** Memory holds 0x12, 0x34, 0x56, 0x78 at 0x100..0x103; load word from 0x100.
  - `bmem_re` on cycles 1–4 with addresses 0x100–0x103.
  - `done` on cycle 5 with `rdata` = 0x12345678.
- **Half loads.** Bytes 0x80, 0x01 at 0x200.
  - Signed half load → `rdata` = 0xFFFF8001.
  - Unsigned half load → `rdata` = 0x00008001.
  - Signed byte load of 0xF0 → 0xFFFFFFF0.
- **Word store with wait states.** Store 0xDEADBEEF to 0x40; `bmem_ready` low for 2 cycles before each byte.
  - Write bytes DE, AD, BE, EF to 0x40–0x43 in order.
  - `done` on cycle 13.
- **Rejected requests.** Half access at 0x201, word access at 0x102, `blockSize` 2'b10, and read+write together.
  - Each gives a `misaligned` pulse on cycle 1.
  - Zero `bmem_re`/`bmem_we` activity.
  - `rdata` unchanged.
- **Reset mid-store.** Assert `rst` during byte 2 of a word store.
  - Strobes low and `busy` = 0 on the next edge; no `done`.
  - A subsequent byte load completes normally in 2 cycles after the strobe cycle.
- **Back-to-back requests.** Hold `start` high continuously with a byte store then a byte load.
  - Second request accepted on the cycle after the first `done`.
  - `busy` drops for exactly one cycle between the two requests.
